// File: rtl/uart_tx.sv
// UART transmitter: one start bit, 1..16 data bits LSB first, optional parity,
// one or two stop bits. Frame format is latched at accept time.
module uart_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] clk_div,
    input  logic [15:0] data_in,
    input  logic        start,
    input  logic [4:0]  bits_per_word,
    input  logic        parity_en,
    input  logic        parity_even_odd,
    input  logic        two_stop_bit,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_STOP2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] data_q, data_d;
    logic [3:0]  last_q, last_d;
    logic [3:0]  idx_q, idx_d;
    logic        par_en_q, par_en_d;
    logic        par_bit_q, par_bit_d;
    logic        two_stop_q, two_stop_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [3:0]  last_in;
    logic [15:0] word_mask;
    logic        parity_in;
    logic        bit_end;

    assign last_in = bits_per_word[4] ? 4'hF : bits_per_word[3:0];

    // Only the bits that will actually be sent contribute to parity.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_mask
            assign word_mask[gi] = (4'(gi) <= last_in);
        end
    endgenerate

    assign parity_in = (^(data_in & word_mask)) ^ parity_even_odd;
    assign bit_end   = (cnt_q == div_q - 16'd1);

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        last_d     = last_q;
        idx_d      = idx_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;
        done_d     = 1'b0;

        if (state_q == S_IDLE) begin
            if (start) begin
                state_d    = S_START;
                div_d      = (clk_div == 16'd0) ? 16'd1 : clk_div;
                cnt_d      = 16'd0;
                data_d     = data_in;
                last_d     = last_in;
                idx_d      = 4'd0;
                par_en_d   = parity_en;
                par_bit_d  = parity_in;
                two_stop_d = two_stop_bit;
            end
        end else if (!bit_end) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = 16'd0;
            case (state_q)
                S_START: begin
                    state_d = S_DATA;
                    idx_d   = 4'd0;
                end
                S_DATA: begin
                    if (idx_q == last_q) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
                S_PARITY: state_d = S_STOP;
                S_STOP: begin
                    if (two_stop_q) begin
                        state_d = S_STOP2;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                S_STOP2: begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Line level is derived from the next state so tx comes straight from a flop.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_q[idx_d];
            S_PARITY: tx_d = par_bit_q;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            div_q      <= 16'd1;
            cnt_q      <= 16'd0;
            data_q     <= 16'd0;
            last_q     <= 4'd0;
            idx_q      <= 4'd0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            last_q     <= last_d;
            idx_q      <= idx_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-level model predicts tx/busy/done for every cycle,
// plus directed checks of frame lengths and selected bit values.
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] clk_div;
    logic [15:0] data_in;
    logic        start;
    logic [4:0]  bits_per_word;
    logic        parity_en;
    logic        parity_even_odd;
    logic        two_stop_bit;
    logic        tx;
    logic        busy;
    logic        done;

    uart_tx dut (
        .clk             (clk),
        .rst             (rst),
        .clk_div         (clk_div),
        .data_in         (data_in),
        .start           (start),
        .bits_per_word   (bits_per_word),
        .parity_en       (parity_en),
        .parity_even_odd (parity_even_odd),
        .two_stop_bit    (two_stop_bit),
        .tx              (tx),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic tx;
        logic busy;
        logic done;
    } exp_t;

    localparam exp_t IDLE_E = 3'b100;

    exp_t exp_q[$];
    int   cyc;
    int   vectors;
    int   miscompares;

    string lit_name[64];
    int    lit_act[64];
    int    lit_exp[64];
    int    lit_n;
    int    lit_k;
    exp_t  cur_e;

    always @(posedge clk) cyc <= cyc + 1;

    // Model: one queue entry per future cycle of the frame, built from the
    // frame rules (start bit, data bits, parity, stop bits, then a done cycle).
    task automatic push_frame();
        int   d;
        int   n;
        logic p;
        d = (clk_div == 16'd0) ? 1 : int'(clk_div);
        n = ((bits_per_word > 5'd15) ? 15 : int'(bits_per_word)) + 1;
        p = parity_even_odd;
        repeat (d) exp_q.push_back(exp_t'(3'b010));
        for (int i = 0; i < n; i++) begin
            p = p ^ data_in[i];
            repeat (d) exp_q.push_back(exp_t'({data_in[i], 2'b10}));
        end
        if (parity_en) repeat (d) exp_q.push_back(exp_t'({p, 2'b10}));
        repeat (two_stop_bit ? 2 * d : d) exp_q.push_back(exp_t'(3'b110));
        exp_q.push_back(exp_t'(3'b101));
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            logic cur_busy;
            cur_busy = (exp_q.size() != 0) ? exp_q[0].busy : 1'b0;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (start && !cur_busy) push_frame();
        end
    end

    always @(negedge clk) begin
        cur_e = (exp_q.size() != 0) ? exp_q[0] : IDLE_E;
        vectors++;
        if ({tx, busy, done} !== cur_e) begin
            miscompares++;
            $display("FAIL line cycle %0d: tx/busy/done got %b%b%b, required %b%b%b",
                     cyc, tx, busy, done, cur_e.tx, cur_e.busy, cur_e.done);
        end
        while (lit_k < lit_n) begin
            vectors++;
            if (lit_act[lit_k] != lit_exp[lit_k]) begin
                miscompares++;
                $display("FAIL %s: got %0d, required %0d",
                         lit_name[lit_k], lit_act[lit_k], lit_exp[lit_k]);
            end
            lit_k++;
        end
    end

    task automatic lit(input string name, input int act, input int expv);
        lit_name[lit_n] = name;
        lit_act[lit_n]  = act;
        lit_exp[lit_n]  = expv;
        lit_n++;
    endtask

    task automatic send(input logic [15:0] div, input logic [15:0] d, input logic [4:0] bpw,
                        input logic pe, input logic odd, input logic two, output int t);
        @(posedge clk);
        #1;
        clk_div         = div;
        data_in         = d;
        bits_per_word   = bpw;
        parity_en       = pe;
        parity_even_odd = odd;
        two_stop_bit    = two;
        start           = 1'b1;
        t               = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic sample_at(input int target, output int v);
        while (cyc < target) @(negedge clk);
        v = int'(tx);
    endtask

    int t;
    int at;
    int v;
    int d1, d2, d3;
    int n_done;

    initial begin
        rst             = 1'b1;
        clk_div         = 16'd0;
        data_in         = 16'd0;
        start           = 1'b0;
        bits_per_word   = 5'd0;
        parity_en       = 1'b0;
        parity_even_odd = 1'b0;
        two_stop_bit    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        lit("reset_tx", int'(tx), 1);
        lit("reset_busy", int'(busy), 0);
        rst = 1'b0;

        // 8N1, divider 4, 0x55: first data bit (1) at T+5, done at T+41
        send(16'd4, 16'h0055, 5'd7, 1'b0, 1'b0, 1'b0, t);
        sample_at(t + 1, v);  lit("t1_start_bit", v, 0);
        sample_at(t + 5, v);  lit("t1_bit0", v, 1);
        sample_at(t + 9, v);  lit("t1_bit1", v, 0);
        wait_done(200, at);   lit("t1_done_at", at - t, 41);

        // 8E1 / 8O1, divider 2, 0x07: parity bit occupies T+19..T+20
        send(16'd2, 16'h0007, 5'd7, 1'b1, 1'b0, 1'b0, t);
        sample_at(t + 19, v); lit("t2_even_parity", v, 1);
        wait_done(200, at);   lit("t2_even_done_at", at - t, 23);
        send(16'd2, 16'h0007, 5'd7, 1'b1, 1'b1, 1'b0, t);
        sample_at(t + 19, v); lit("t2_odd_parity", v, 0);
        wait_done(200, at);   lit("t2_odd_done_at", at - t, 23);

        // 16 data bits, two stops, divider 3, 0xA5C3
        send(16'd3, 16'hA5C3, 5'd15, 1'b0, 1'b0, 1'b1, t);
        sample_at(t + 10, v); lit("t3_bit2", v, 0);
        sample_at(t + 52, v); lit("t3_stop", v, 1);
        wait_done(200, at);   lit("t3_done_at", at - t, 58);

        // Second start mid-frame with different data and divider is ignored
        send(16'd4, 16'h000F, 5'd7, 1'b0, 1'b0, 1'b0, t);
        repeat (4) @(posedge clk);
        #1;
        data_in = 16'hFFF0;
        clk_div = 16'd1;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        n_done = 0;
        at     = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (at < 0) at = cyc;
            end
        end
        lit("t4_done_count", n_done, 1);
        lit("t4_done_at", at - t, 41);

        // start held high, divider 1, 5 data bits: 7-cycle frame plus done cycle
        @(posedge clk);
        #1;
        clk_div         = 16'd1;
        data_in         = 16'h0015;
        bits_per_word   = 5'd4;
        parity_en       = 1'b0;
        two_stop_bit    = 1'b0;
        start           = 1'b1;
        t               = cyc;
        wait_done(50, d1);
        wait_done(50, d2);
        wait_done(50, d3);
        lit("t5_first_done", d1 - t, 8);
        lit("t5_period_a", d2 - d1, 8);
        lit("t5_period_b", d3 - d2, 8);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(50, at);

        // Divider 0 behaves as 1; word length field 31 saturates to 16 bits
        send(16'd0, 16'h0001, 5'd0, 1'b0, 1'b0, 1'b0, t);
        wait_done(50, at);    lit("div0_done_at", at - t, 4);
        send(16'd1, 16'hFFFF, 5'd31, 1'b0, 1'b0, 1'b0, t);
        wait_done(50, at);    lit("bpw31_done_at", at - t, 19);

        // Reset in the middle of the data bits aborts the frame at once
        send(16'd2, 16'h003C, 5'd7, 1'b0, 1'b0, 1'b0, t);
        sample_at(t + 6, v);
        #1;
        rst = 1'b1;
        #1;
        lit("t6_rst_tx", int'(tx), 1);
        lit("t6_rst_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        send(16'd2, 16'h003C, 5'd7, 1'b0, 1'b0, 1'b0, t);
        sample_at(t + 7, v);  lit("t6_bit2", v, 1);
        wait_done(100, at);   lit("t6_done_at", at - t, 21);

        repeat (3) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
